// File: rtl/mig_rd_checker.sv
// mig_rd_checker
//   Passive checker for MIG UI read traffic. Snoops accepted read commands
//   into an address FIFO, then compares every returned read beat against an
//   address-derived pattern: 32-bit word {beat_idx, addr[30:0]} replicated
//   across the data bus. Bursts are two beats.
//
// Ports
//   clk, reset            UI clock, synchronous active-high reset
//   app_en/app_rdy/app_cmd/app_addr   snooped command channel (3'b001 = read)
//   app_rd_data_valid/_end/app_rd_data snooped read data channel
//   error                 sticky OR of every fault
//   mismatch              one-cycle pulse, one cycle after a miscompared beat
//   err_count             miscompared beats, saturating
//   rd_count              completed two-beat bursts, wrapping
//   first_err_addr        address of the first miscompared beat
//   overflow_err          sticky: read accepted while the FIFO was full
//   underflow_err         sticky: beat arrived with the FIFO empty
//   framing_err           sticky: app_rd_data_end on the wrong beat
//   outstanding           current FIFO occupancy
module mig_rd_checker #(
  parameter int ADDR_WIDTH      = 27,
  parameter int APP_DATA_WIDTH  = 256,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 app_en,
  input  logic                                 app_rdy,
  input  logic [2:0]                           app_cmd,
  input  logic [ADDR_WIDTH-1:0]                app_addr,
  input  logic                                 app_rd_data_valid,
  input  logic                                 app_rd_data_end,
  input  logic [APP_DATA_WIDTH-1:0]            app_rd_data,
  output logic                                 error,
  output logic                                 mismatch,
  output logic [15:0]                          err_count,
  output logic [31:0]                          rd_count,
  output logic [ADDR_WIDTH-1:0]                first_err_addr,
  output logic                                 overflow_err,
  output logic                                 underflow_err,
  output logic                                 framing_err,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding
);

  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;
  localparam int NWORDS = APP_DATA_WIDTH / 32;

  localparam logic [0:0] BEAT0 = 1'b0;
  localparam logic [0:0] BEAT1 = 1'b1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [ADDR_WIDTH-1:0] r_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [0:0]            r_state;

  logic                  r_error;
  logic                  r_mismatch;
  logic [15:0]           r_err_count;
  logic [31:0]           r_rd_count;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_framing;

  logic                      w_push_req;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_empty;
  logic                      w_full;
  logic                      w_overflow;
  logic                      w_underflow;
  logic                      w_beat_ok;
  logic                      w_framing;
  logic                      w_miscmp;
  logic [ADDR_WIDTH-1:0]     w_head;
  logic [ADDR_WIDTH+30:0]    w_head_ext;
  logic [31:0]               w_word;
  logic [APP_DATA_WIDTH-1:0] w_expected;

  assign w_push_req = app_en && app_rdy && (app_cmd == 3'b001);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);

  // A beat with nothing outstanding is flagged but otherwise ignored.
  assign w_beat_ok   = app_rd_data_valid && !w_empty;
  assign w_underflow = app_rd_data_valid && w_empty;

  // A stray end on beat 0 still retires the head so the stream resyncs.
  assign w_pop = w_beat_ok && ((r_state == BEAT1) || app_rd_data_end);

  // A pop in the same cycle frees the slot, so push-at-full is legal then.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_overflow = w_push_req && w_full && !w_pop;

  assign w_framing = w_beat_ok &&
                     (((r_state == BEAT0) &&  app_rd_data_end) ||
                      ((r_state == BEAT1) && !app_rd_data_end));

  // Zero-extend or truncate the head address to 31 bits for any ADDR_WIDTH.
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_ext = {{31{1'b0}}, w_head};
  assign w_word     = {r_state, w_head_ext[30:0]};
  assign w_expected = {NWORDS{w_word}};

  assign w_miscmp = w_beat_ok && (app_rd_data != w_expected);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= app_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_state          <= BEAT0;
      r_error          <= 1'b0;
      r_mismatch       <= 1'b0;
      r_err_count      <= '0;
      r_rd_count       <= '0;
      r_first_err_addr <= '0;
      r_overflow       <= 1'b0;
      r_underflow      <= 1'b0;
      r_framing        <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

      if (w_beat_ok) begin
        if (r_state == BEAT0) begin
          if (!app_rd_data_end) r_state <= BEAT1;
        end else begin
          r_state    <= BEAT0;
          r_rd_count <= r_rd_count + 32'd1;
        end
      end

      if (w_overflow)  r_overflow  <= 1'b1;
      if (w_underflow) r_underflow <= 1'b1;
      if (w_framing)   r_framing   <= 1'b1;

      r_mismatch <= w_miscmp;
      if (w_miscmp) begin
        if (r_err_count == '0)  r_first_err_addr <= w_head;
        if (r_err_count != '1)  r_err_count      <= r_err_count + 16'd1;
      end

      // Built from this cycle's events so it rises together with the flags.
      r_error <= r_error | w_overflow | w_underflow | w_framing | w_miscmp;
    end
  end

  assign error          = r_error;
  assign mismatch       = r_mismatch;
  assign err_count      = r_err_count;
  assign rd_count       = r_rd_count;
  assign first_err_addr = r_first_err_addr;
  assign overflow_err   = r_overflow;
  assign underflow_err  = r_underflow;
  assign framing_err    = r_framing;
  assign outstanding    = r_count;

endmodule

// File: tb/tb_mig_rd_checker.sv
module tb_mig_rd_checker;

  logic         clk;
  logic         reset;
  logic         app_en;
  logic         app_rdy;
  logic [2:0]   app_cmd;
  logic [26:0]  app_addr;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic [255:0] app_rd_data;
  logic         error;
  logic         mismatch;
  logic [15:0]  err_count;
  logic [31:0]  rd_count;
  logic [26:0]  first_err_addr;
  logic         overflow_err;
  logic         underflow_err;
  logic         framing_err;
  logic [4:0]   outstanding;

  int total = 0;
  int bad   = 0;

  mig_rd_checker #(
    .ADDR_WIDTH      (27),
    .APP_DATA_WIDTH  (256),
    .MAX_OUTSTANDING (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .app_en            (app_en),
    .app_rdy           (app_rdy),
    .app_cmd           (app_cmd),
    .app_addr          (app_addr),
    .app_rd_data_valid (app_rd_data_valid),
    .app_rd_data_end   (app_rd_data_end),
    .app_rd_data       (app_rd_data),
    .error             (error),
    .mismatch          (mismatch),
    .err_count         (err_count),
    .rd_count          (rd_count),
    .first_err_addr    (first_err_addr),
    .overflow_err      (overflow_err),
    .underflow_err     (underflow_err),
    .framing_err       (framing_err),
    .outstanding       (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected beat: {beat, 4'b0, addr[26:0]} in every 32-bit lane.
  function automatic logic [255:0] pat(input logic [26:0] a, input logic b);
    logic [31:0] w;
    w = {b, 4'b0000, a};
    return {8{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    app_en = 0; app_rdy = 0; app_cmd = 3'b000; app_addr = '0;
    app_rd_data_valid = 0; app_rd_data_end = 0; app_rd_data = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic rdy, input logic [26:0] a);
    app_en = 1; app_rdy = rdy; app_cmd = cmd; app_addr = a;
    tick();
    app_en = 0; app_rdy = 0; app_cmd = 3'b000;
  endtask

  task automatic send_beat(input logic [255:0] d, input logic e);
    app_rd_data_valid = 1; app_rd_data = d; app_rd_data_end = e;
    tick();
    app_rd_data_valid = 0; app_rd_data_end = 0; app_rd_data = '0;
  endtask

  task automatic send_burst(input logic [26:0] a);
    send_beat(pat(a, 1'b0), 1'b0);
    send_beat(pat(a, 1'b1), 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (error !== 1'b0)          begin bad++; $display("FAIL reset_error got=%0b exp=0", error); end
    total++; if (mismatch !== 1'b0)       begin bad++; $display("FAIL reset_mismatch got=%0b exp=0", mismatch); end
    total++; if (err_count !== 16'd0)     begin bad++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    total++; if (rd_count !== 32'd0)      begin bad++; $display("FAIL reset_rd_count got=%0d exp=0", rd_count); end
    total++; if (first_err_addr !== 27'd0) begin bad++; $display("FAIL reset_first_err_addr got=%h exp=0", first_err_addr); end
    total++; if ({overflow_err, underflow_err, framing_err} !== 3'b000)
      begin bad++; $display("FAIL reset_flags got=%b exp=000", {overflow_err, underflow_err, framing_err}); end
    total++; if (outstanding !== 5'd0)    begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
  endtask

  task automatic test_cmd_filter();
    do_reset();
    send_cmd(3'b000, 1'b1, 27'h40);   // write
    send_cmd(3'b011, 1'b1, 27'h40);   // other command
    send_cmd(3'b001, 1'b0, 27'h40);   // read, not ready
    total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL filter_outstanding got=%0d exp=0", outstanding); end
  endtask

  task automatic test_correct();
    do_reset();
    send_cmd(3'b001, 1'b1, 27'h40);
    total++; if (outstanding !== 5'd1) begin bad++; $display("FAIL correct_out_after_push got=%0d exp=1", outstanding); end
    send_beat({8{32'h0000_0040}}, 1'b0);
    total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL correct_mismatch0 got=%0b exp=0", mismatch); end
    tick(); tick();   // gap between beats
    total++; if (outstanding !== 5'd1) begin bad++; $display("FAIL correct_out_gap got=%0d exp=1", outstanding); end
    send_beat({8{32'h8000_0040}}, 1'b1);
    total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL correct_mismatch1 got=%0b exp=0", mismatch); end
    total++; if (rd_count !== 32'd1) begin bad++; $display("FAIL correct_rd_count got=%0d exp=1", rd_count); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL correct_err_count got=%0d exp=0", err_count); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL correct_error got=%0b exp=0", error); end
    total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL correct_outstanding got=%0d exp=0", outstanding); end
  endtask

  task automatic test_bitflip();
    logic [255:0] d;
    do_reset();
    send_cmd(3'b001, 1'b1, 27'h0);
    send_cmd(3'b001, 1'b1, 27'h40);
    send_burst(27'h0);
    send_beat(pat(27'h40, 1'b0), 1'b0);
    total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL flip_pre_mismatch got=%0b exp=0", mismatch); end
    d = {8{32'h8000_0040}};
    d[5] = ~d[5];
    send_beat(d, 1'b1);
    total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL flip_mismatch got=%0b exp=1", mismatch); end
    total++; if (err_count !== 16'd1) begin bad++; $display("FAIL flip_err_count got=%0d exp=1", err_count); end
    total++; if (first_err_addr !== 27'h40) begin bad++; $display("FAIL flip_first_err_addr got=%h exp=40", first_err_addr); end
    total++; if (rd_count !== 32'd2) begin bad++; $display("FAIL flip_rd_count got=%0d exp=2", rd_count); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL flip_error got=%0b exp=1", error); end
    tick();
    total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL flip_pulse_width got=%0b exp=0", mismatch); end
    // second miscompare: counter advances, first address held
    send_cmd(3'b001, 1'b1, 27'h80);
    send_beat(pat(27'h81, 1'b0), 1'b0);
    send_beat(pat(27'h80, 1'b1), 1'b1);
    total++; if (err_count !== 16'd2) begin bad++; $display("FAIL flip2_err_count got=%0d exp=2", err_count); end
    total++; if (first_err_addr !== 27'h40) begin bad++; $display("FAIL flip2_first_err_addr got=%h exp=40", first_err_addr); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) send_cmd(3'b001, 1'b1, 27'(i * 64));
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b exp=0", overflow_err); end
    send_cmd(3'b001, 1'b1, 27'h7FF);
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow_err); end
    total++; if (outstanding !== 5'd16) begin bad++; $display("FAIL ovf_outstanding got=%0d exp=16", outstanding); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL ovf_error got=%0b exp=1", error); end
    for (int i = 0; i < 16; i++) send_burst(27'(i * 64));
    total++; if (rd_count !== 32'd16) begin bad++; $display("FAIL ovf_rd_count got=%0d exp=16", rd_count); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL ovf_err_count got=%0d exp=0", err_count); end
    total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL ovf_drain got=%0d exp=0", outstanding); end
  endtask

  task automatic test_underflow();
    do_reset();
    send_beat({8{32'hDEAD_BEEF}}, 1'b1);
    total++; if (underflow_err !== 1'b1) begin bad++; $display("FAIL unf_flag got=%0b exp=1", underflow_err); end
    total++; if (rd_count !== 32'd0) begin bad++; $display("FAIL unf_rd_count got=%0d exp=0", rd_count); end
    total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL unf_mismatch got=%0b exp=0", mismatch); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL unf_error got=%0b exp=1", error); end
    total++; if (framing_err !== 1'b0) begin bad++; $display("FAIL unf_framing got=%0b exp=0", framing_err); end
  endtask

  task automatic test_framing();
    do_reset();
    send_cmd(3'b001, 1'b1, 27'h80);
    send_beat(pat(27'h80, 1'b0), 1'b1);
    total++; if (framing_err !== 1'b1) begin bad++; $display("FAIL frm_flag got=%0b exp=1", framing_err); end
    total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL frm_popped got=%0d exp=0", outstanding); end
    total++; if (rd_count !== 32'd0) begin bad++; $display("FAIL frm_rd_count got=%0d exp=0", rd_count); end
    send_cmd(3'b001, 1'b1, 27'h100);
    send_burst(27'h100);
    total++; if (rd_count !== 32'd1) begin bad++; $display("FAIL frm_resync_rd_count got=%0d exp=1", rd_count); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL frm_err_count got=%0d exp=0", err_count); end
    // beat1 without end is also a framing fault but completes the burst
    do_reset();
    send_cmd(3'b001, 1'b1, 27'h10);
    send_beat(pat(27'h10, 1'b0), 1'b0);
    send_beat(pat(27'h10, 1'b1), 1'b0);
    total++; if ({framing_err, rd_count[0], outstanding} !== {1'b1, 1'b1, 5'd0})
      begin bad++; $display("FAIL frm_beat1 got=%b exp=1100000", {framing_err, rd_count[0], outstanding}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 16; i++) send_cmd(3'b001, 1'b1, 27'(i * 64));
    send_beat(pat(27'h0, 1'b0), 1'b0);
    // pop of the old head and push of a new tail in one cycle at full
    app_en = 1; app_rdy = 1; app_cmd = 3'b001; app_addr = 27'h400;
    app_rd_data_valid = 1; app_rd_data_end = 1; app_rd_data = pat(27'h0, 1'b1);
    tick();
    idle();
    total++; if (outstanding !== 5'd16) begin bad++; $display("FAIL b2b_outstanding got=%0d exp=16", outstanding); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%0b exp=0", overflow_err); end
    total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL b2b_mismatch got=%0b exp=0", mismatch); end
    for (int i = 1; i < 16; i++) send_burst(27'(i * 64));
    send_burst(27'h400);
    total++; if (rd_count !== 32'd17) begin bad++; $display("FAIL b2b_rd_count got=%0d exp=17", rd_count); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL b2b_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    send_cmd(3'b001, 1'b1, 27'h40);
    send_cmd(3'b001, 1'b1, 27'h80);
    send_beat(pat(27'h40, 1'b0), 1'b0);
    do_reset();
    total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL mid_outstanding got=%0d exp=0", outstanding); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL mid_error got=%0b exp=0", error); end
    send_cmd(3'b001, 1'b1, 27'h40);
    send_burst(27'h40);
    total++; if (rd_count !== 32'd1) begin bad++; $display("FAIL mid_rd_count got=%0d exp=1", rd_count); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL mid_error_after got=%0b exp=0", error); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL mid_err_count got=%0d exp=0", err_count); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    test_reset();
    test_cmd_filter();
    test_correct();
    test_bitflip();
    test_overflow();
    test_underflow();
    test_framing();
    test_back_to_back();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
